// File: rtl/score_digit_counter.sv
// score_digit_counter
//   Game score/lives tracker for a brick-breaker style game. Keeps a
//   three-digit BCD score that saturates at MAX_SCORE, a lives counter
//   loaded with START_LIVES, and an IDLE/PLAY/OVER state machine driven
//   by rising edges of the start, hit and miss levels.
//
//   Optional feature macro: SCORE_BLANK_EN -- when defined, leading zero
//   digits of the score are blanked (code 5'b11111) on dig2/dig1.
//
// Ports
//   clk        : system clock, rising edge active
//   rst        : asynchronous active-high reset
//   start      : start key level (rising edge acted on)
//   hit        : brick-hit level (rising edge acted on)
//   miss       : ball-lost level (rising edge acted on)
//   dig0       : score ones digit code
//   dig1       : score tens digit code
//   dig2       : score hundreds digit code
//   dig_lives  : remaining-lives digit code
//   game_over  : registered, high while in OVER
//   state      : IDLE=00, PLAY=01, OVER=10
module score_digit_counter #(
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned MAX_SCORE   = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [4:0] dig0,
  output logic [4:0] dig1,
  output logic [4:0] dig2,
  output logic [4:0] dig_lives,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [3:0] LIVES0 = 4'(START_LIVES);
  localparam logic [3:0] MAX_H  = 4'(MAX_SCORE / 100);
  localparam logic [3:0] MAX_T  = 4'((MAX_SCORE / 10) % 10);
  localparam logic [3:0] MAX_O  = 4'(MAX_SCORE % 10);

  state_t     cur, nxt;
  logic       start_q, hit_q, miss_q;
  logic       armed;
  logic       start_e, hit_e, miss_e;
  logic [3:0] ones, tens, hund, lives;
  logic [3:0] n_ones, n_tens, n_hund, n_lives;
  logic       at_max;

  // The history registers clear to 0 in reset, so a level already high at
  // release would look like an edge; 'armed' masks edges for that first
  // clock so only genuine low-to-high transitions count.
  assign start_e = armed & start & ~start_q;
  assign hit_e   = armed & hit   & ~hit_q;
  assign miss_e  = armed & miss  & ~miss_q;

  assign at_max = (hund == MAX_H) && (tens == MAX_T) && (ones == MAX_O);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= IDLE;
      start_q   <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      armed     <= 1'b0;
      ones      <= '0;
      tens      <= '0;
      hund      <= '0;
      lives     <= LIVES0;
      game_over <= 1'b0;
    end else begin
      cur       <= nxt;
      start_q   <= start;
      hit_q     <= hit;
      miss_q    <= miss;
      armed     <= 1'b1;
      ones      <= n_ones;
      tens      <= n_tens;
      hund      <= n_hund;
      lives     <= n_lives;
      game_over <= (nxt == OVER);
    end
  end

  always_comb begin
    nxt     = cur;
    n_ones  = ones;
    n_tens  = tens;
    n_hund  = hund;
    n_lives = lives;
    case (cur)
      IDLE: begin
        n_ones  = '0;
        n_tens  = '0;
        n_hund  = '0;
        n_lives = LIVES0;
        if (start_e) nxt = PLAY;
      end
      PLAY: begin
        if (hit_e && !at_max) begin
          if (ones == 4'd9) begin
            n_ones = '0;
            if (tens == 4'd9) begin
              n_tens = '0;
              n_hund = hund + 4'd1;
            end else begin
              n_tens = tens + 4'd1;
            end
          end else begin
            n_ones = ones + 4'd1;
          end
        end
        if (miss_e) begin
          n_lives = lives - 4'd1;
          if (lives == 4'd1) nxt = OVER;
        end
      end
      OVER: begin
        if (start_e) begin
          n_ones  = '0;
          n_tens  = '0;
          n_hund  = '0;
          n_lives = LIVES0;
          nxt     = PLAY;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign state     = cur;
  assign dig_lives = {1'b0, lives};
  assign dig0      = {1'b0, ones};

`ifdef SCORE_BLANK_EN
  assign dig2 = (hund == 4'd0) ? 5'b11111 : {1'b0, hund};
  assign dig1 = ((hund == 4'd0) && (tens == 4'd0)) ? 5'b11111 : {1'b0, tens};
`else
  assign dig2 = {1'b0, hund};
  assign dig1 = {1'b0, tens};
`endif

endmodule

// File: tb/tb_score_digit_counter.sv
module tb_score_digit_counter;

  localparam int unsigned SL = 3;
  localparam int unsigned MS = 999;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [4:0] dig0, dig1, dig2, dig_lives;
  logic       game_over;
  logic [1:0] state;

  score_digit_counter #(.START_LIVES(SL), .MAX_SCORE(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig_lives(dig_lives),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] d2, d1, d0, dl;
    logic       go;
    logic [1:0] st;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   errors  = 0;

  // Reference model: score as an integer, lives as an integer, mode 0/1/2.
  int m_score, m_lives, m_mode;
  bit pv_s, pv_h, pv_m;

  function automatic exp_t expect_now();
    exp_t e;
    int h, t, o;
    h = m_score / 100;
    t = (m_score / 10) % 10;
    o = m_score % 10;
    e.d0 = 5'(o);
    e.d1 = 5'(t);
    e.d2 = 5'(h);
`ifdef SCORE_BLANK_EN
    if (h == 0) e.d2 = 5'b11111;
    if (h == 0 && t == 0) e.d1 = 5'b11111;
`endif
    e.dl = 5'(m_lives);
    e.go = (m_mode == 2);
    e.st = 2'(m_mode);
    return e;
  endfunction

  function automatic void model_step(input bit r, input bit s, input bit h, input bit m);
    bit es, eh, em;
    if (r) begin
      m_score = 0; m_lives = SL; m_mode = 0;
      // anything already high when reset releases is not an edge
      pv_s = 1; pv_h = 1; pv_m = 1;
      return;
    end
    es = s && !pv_s;
    eh = h && !pv_h;
    em = m && !pv_m;
    pv_s = s; pv_h = h; pv_m = m;
    case (m_mode)
      0: if (es) m_mode = 1;
      1: begin
        if (eh && m_score < MS) m_score++;
        if (em) begin
          m_lives--;
          if (m_lives == 0) m_mode = 2;
        end
      end
      default: if (es) begin m_score = 0; m_lives = SL; m_mode = 1; end
    endcase
  endfunction

  function automatic void compare(input string name, input exp_t e);
    exp_t got;
    got = '{d2: dig2, d1: dig1, d0: dig0, dl: dig_lives, go: game_over, st: state};
    vectors++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got d2=%0d d1=%0d d0=%0d lives=%0d go=%0b st=%0d, want d2=%0d d1=%0d d0=%0d lives=%0d go=%0b st=%0d",
               name, $time, got.d2, got.d1, got.d0, got.dl, got.go, got.st,
               e.d2, e.d1, e.d0, e.dl, e.go, e.st);
    end
  endfunction

  // Drive one cycle's input levels and queue the response expected after the edge.
  task automatic cyc(input bit r, input bit s, input bit h, input bit m);
    @(negedge clk);
    rst = r; start = s; hit = h; miss = m;
    model_step(r, s, h, m);
    expq.push_back(expect_now());
  endtask

  task automatic pulse(input bit s, input bit h, input bit m);
    cyc(0, s, h, m);
    cyc(0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, checked just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) compare("out", expq.pop_front());
    end
  end

  initial begin
    bit s, h, m;
    model_step(1, 0, 0, 0);
    // reset, with start held high across release: no edge
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 1);
    cyc(0, 0, 0, 0);
    // start edge enters PLAY
    pulse(1, 0, 0);
    pulse(1, 0, 0);        // ignored in PLAY
    // 12 hit pulses, then a long hit counts once
    for (int i = 0; i < 12; i++) pulse(0, 1, 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    // run the score up to saturation and beyond
    while (m_score < MS) pulse(0, 1, 0);
    for (int i = 0; i < 3; i++) pulse(0, 1, 0);
    // lose all lives
    while (m_mode == 1) pulse(0, 0, 1);
    pulse(0, 1, 1);        // ignored in OVER
    pulse(1, 0, 0);        // restart
    for (int i = 0; i < 7; i++) pulse(0, 1, 0);
    cyc(0, 0, 0, 0);
    while (m_score < 40) pulse(0, 1, 0);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    pulse(0, 1, 1);        // simultaneous hit and last miss
    cyc(0, 0, 0, 0);
    pulse(1, 0, 0);        // OVER -> PLAY
    for (int i = 0; i < 5; i++) pulse(0, 1, 0);
    // asynchronous reset mid-PLAY, checked before any clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_step(1, 0, 0, 0);
    compare("async_rst", expect_now());
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    pulse(1, 0, 0);        // first edge after reset honoured
    // randomized play
    s = 0; h = 0; m = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r;
      if ($urandom_range(0, 99) < 45) h = !h;
      if ($urandom_range(0, 99) < 8)  m = !m;
      if ($urandom_range(0, 99) < 6)  s = !s;
      r = ($urandom_range(0, 999) < 3);
      cyc(r, s, h, m);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
